// File: rtl/fib_acc_arbiter.sv
// Round-robin arbiter and sequencer for the shared Fibonacci accumulator
// (x <= x + y, y <= x). It runs one requester's job to a threshold, overflow or step limit.
module fib_acc_arbiter #(
    parameter  int W       = 8,
    parameter  int MAXSTEP = 16,
    localparam int CW      = $clog2(MAXSTEP + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [W-1:0]  x0_seed,
    input  logic [W-1:0]  y0_seed,
    input  logic [W-1:0]  thr0,
    input  logic [W-1:0]  x1_seed,
    input  logic [W-1:0]  y1_seed,
    input  logic [W-1:0]  thr1,
    output logic [1:0]    gnt,
    output logic          busy,
    output logic          done,
    output logic          done_id,
    output logic [W-1:0]  res_x,
    output logic [CW-1:0] res_steps,
    output logic          res_hit,
    output logic          res_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state, state_nx;
    logic          rr_ptr, rr_ptr_nx;
    logic          winner, winner_nx;
    logic          pick;
    logic [W-1:0]  x, x_nx;
    logic [W-1:0]  y, y_nx;
    logic [W-1:0]  thr, thr_nx;
    logic [CW-1:0] step, step_nx;
    logic [W-1:0]  res_x_nx;
    logic [CW-1:0] res_steps_nx;
    logic          res_hit_nx;
    logic          res_ovf_nx;
    logic [W:0]    sum;

    // One extra bit so the adder's carry-out is visible as sum[W].
    assign sum = {1'b0, x} + {1'b0, y};

    // With both requesting, rr_ptr breaks the tie; otherwise the single requester wins.
    assign pick = (req == 2'b11) ? rr_ptr : req[1];

    always_comb begin
        // NOTE: every next-state signal gets a hold default first, so no path can infer a latch.
        state_nx     = state;
        rr_ptr_nx    = rr_ptr;
        winner_nx    = winner;
        x_nx         = x;
        y_nx         = y;
        thr_nx       = thr;
        step_nx      = step;
        res_x_nx     = res_x;
        res_steps_nx = res_steps;
        res_hit_nx   = res_hit;
        res_ovf_nx   = res_ovf;

        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    winner_nx = pick;
                    x_nx      = pick ? x1_seed : x0_seed;
                    y_nx      = pick ? y1_seed : y0_seed;
                    thr_nx    = pick ? thr1 : thr0;
                    step_nx   = '0;
                    state_nx  = RUN;
                end
            end

            RUN: begin
                if (x >= thr) begin
                    res_x_nx     = x;
                    res_steps_nx = step;
                    res_hit_nx   = 1'b1;
                    res_ovf_nx   = 1'b0;
                    state_nx     = DONE;
                end else if (step == CW'(MAXSTEP)) begin
                    res_x_nx     = x;
                    res_steps_nx = step;
                    res_hit_nx   = 1'b0;
                    res_ovf_nx   = 1'b0;
                    state_nx     = DONE;
                end else if (sum[W]) begin
                    // The wrapped sum is kept as the result; the failed step is not counted.
                    x_nx         = sum[W-1:0];
                    res_x_nx     = sum[W-1:0];
                    res_steps_nx = step;
                    res_hit_nx   = 1'b0;
                    res_ovf_nx   = 1'b1;
                    state_nx     = DONE;
                end else begin
                    x_nx    = sum[W-1:0];
                    y_nx    = x;
                    step_nx = step + CW'(1);
                end
            end

            DONE: begin
                rr_ptr_nx = ~winner;
                state_nx  = IDLE;
            end

            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            winner    <= 1'b0;
            x         <= '0;
            y         <= '0;
            thr       <= '0;
            step      <= '0;
            res_x     <= '0;
            res_steps <= '0;
            res_hit   <= 1'b0;
            res_ovf   <= 1'b0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_ptr_nx;
            winner    <= winner_nx;
            x         <= x_nx;
            y         <= y_nx;
            thr       <= thr_nx;
            step      <= step_nx;
            res_x     <= res_x_nx;
            res_steps <= res_steps_nx;
            res_hit   <= res_hit_nx;
            res_ovf   <= res_ovf_nx;
        end
    end

    // Grant spans RUN and DONE, so it follows directly from the state and the winner.
    assign busy    = (state != IDLE);
    assign gnt     = busy ? (winner ? 2'b10 : 2'b01) : 2'b00;
    assign done    = (state == DONE);
    assign done_id = winner;

endmodule
